// File: rtl/fir_pkg.sv
// fir_pkg: types shared across the FIR accelerator stages
package fir_pkg;
  localparam int FIR_DATA_W = 16;
  localparam int FIR_RATE_W = 8;
  typedef logic [FIR_RATE_W-1:0] FIR_RATE;
  typedef struct packed {
    logic                  valid;
    logic [FIR_DATA_W-1:0] data;
  } FIR_DATA_BUS;
  typedef struct packed {
    FIR_RATE rate;
    logic    flush;
  } FIR_CONT_TO_IN_RATE;
  typedef enum logic {SAMPLE, ZERO} IN_RATE_STATE;
endpackage

// File: rtl/in_rate_if.sv
// in_rate_if: controller, DMA and compute-side signals of the input rate stage
interface in_rate_if;
  import fir_pkg::*;
  FIR_CONT_TO_IN_RATE from_cont;
  FIR_DATA_BUS        from_dma;
  logic               in_rate_ready;
  FIR_DATA_BUS        to_compute;
  logic               compute_ready;
  modport master (output from_cont, from_dma, compute_ready, input in_rate_ready, to_compute);
  modport slave (input from_cont, from_dma, compute_ready, output in_rate_ready, to_compute);
endinterface

// File: rtl/d0fifo_wrap.sv
// d0fifo_wrap: show-ahead FIFO; the head entry is on rdata with no read latency
module d0fifo_wrap #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(SIZE);
  logic [WIDTH-1:0] mem_q [SIZE];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  assign rdata = mem_q[rp_q];
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(SIZE);
  // callers never push when full nor pop when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wp_q] <= wdata;
  end
endmodule

// File: rtl/in_rate.sv
// in_rate: input FIFO plus zero-insertion upsampler feeding the FIR compute stage
module in_rate
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  in_rate_if.slave io
);
  IN_RATE_STATE state_q, state_d;
  FIR_RATE      zcnt_q, zcnt_d, rate_q, rate_d;
  FIR_DATA_BUS  out_q, out_d, rdata;
  logic         run_q, empty, full, pop, push, may_load, flush;
  assign flush            = io.from_cont.flush;
  assign io.in_rate_ready = run_q && !full && !flush;
  assign push             = io.from_dma.valid && io.in_rate_ready;
  assign may_load         = !out_q.valid || io.compute_ready;
  assign io.to_compute    = out_q;
  d0fifo_wrap #(.SIZE(DEPTH), .WIDTH($bits(FIR_DATA_BUS))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (io.from_dma),
    .pop   (pop),
    .rdata (rdata),
    .empty (empty),
    .full  (full)
  );
  // rate is sampled only when a new input sample is taken
  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    rate_d  = rate_q;
    out_d   = out_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = SAMPLE;
      zcnt_d  = '0;
      out_d   = '0;
    end else if (may_load && state_q == ZERO) begin
      out_d   = '{valid: 1'b1, data: '0};
      zcnt_d  = zcnt_q + 1'b1;
      state_d = (zcnt_q == rate_q - 1'b1) ? SAMPLE : ZERO;
    end else if (may_load) begin
      pop     = !empty;
      out_d   = empty ? '0 : '{valid: 1'b1, data: rdata.data};
      rate_d  = empty ? rate_q : io.from_cont.rate;
      zcnt_d  = '0;
      state_d = (!empty && io.from_cont.rate != '0) ? ZERO : SAMPLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SAMPLE;
      zcnt_q  <= '0;
      rate_q  <= '0;
      out_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
      rate_q  <= rate_d;
      out_q   <= out_d;
      run_q   <= 1'b1;
    end
  end
endmodule

// File: doc/in_rate.md
# in_rate

Input-side rate stage of the FIR accelerator: accepts samples from DMA, buffers them in a small FIFO and forwards them to the compute stage, optionally upsampling by zero insertion. Counterpart of the output downsampler: `rate = 0` means pass-through, and `rate = R > 0` means interpolation by R+1, with each input sample followed by R zero-valued samples. Sits between the DMA read port and the FIR compute stage, under control of the FIR controller.

## Interface
- `DEPTH`, 4: input FIFO entries (power of two, ≥2).
- `clk`  in  1  clock.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `from_cont`  in  `FIR_CONT_TO_IN_RATE`  controller fields:
  - `rate` (`FIR_RATE`): zeros inserted per sample.
  - `flush` (1): synchronous clear.
- `from_dma`  in  `FIR_DATA_BUS`  `{valid, data}` sample from DMA.
- `in_rate_ready`  out  1  block can accept `from_dma` this cycle.
- `to_compute`  out  `FIR_DATA_BUS`  registered sample to compute.
- `compute_ready`  in  1  compute accepts `to_compute` this cycle.

## Operation
- Input accept: push = `from_dma.valid && in_rate_ready`. `in_rate_ready = !full && !flush`. Data is dropped when `valid` is high while not ready; DMA must hold the sample.
- Output transfer: occurs when `to_compute.valid && compute_ready`. Output register may load when `!to_compute.valid || compute_ready`, i.e. when it is empty or being drained.
- FSM, 2 states:
  - SAMPLE:
    - If the output may load and the FIFO is not empty: pop the FIFO and load `{1, rdata.data}`. Latch `rate_q = rate`.
    - If `rate_q != 0`, clear `zcnt` and go to ZERO.
    - If the FIFO is empty and the output may load, load `valid = 0`.
  - ZERO:
    - Each time the output may load, load `{1, 0}` and increment `zcnt`.
    - When `zcnt == rate_q - 1` on a load, return to SAMPLE.
    - No FIFO pop in ZERO. Push still permitted.
- `rate` is sampled only at the start of each input sample. A mid-burst change takes effect from the next sample.
- Counter `zcnt` is `FIR_RATE` wide and compares against `rate_q - 1`, so the maximum `rate` (all ones) yields 2^W−1 zeros with no wrap.
- Flush (level):
  - While high: FIFO emptied, FSM forced to SAMPLE, `zcnt = 0`, output register loaded with 0, `in_rate_ready = 0`.
  - A push in the same cycle is ignored. Flush dominates pop and load.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, but `in_rate_ready` is still low (registered full). No push that cycle.

## Timing
- Reset values: `to_compute = 0`, `in_rate_ready = 0` while `rst_n` is low, then 1 from the first cycle after reset (FIFO empty). FSM is SAMPLE, `zcnt = 0`, `rate_q = 0`.
- Latency: a sample pushed at edge E0 appears on `to_compute` after edge E1, one cycle, assuming an empty pipeline and `compute_ready = 1`.
- Throughput with continuous `compute_ready`:
  - Pass-through: one output per cycle.
  - Upsample: exactly R+1 consecutive valid outputs per input sample, with no bubbles while the FIFO is non-empty.
- Backpressure: `to_compute` holds its value and valid while `compute_ready = 0`. No zero or sample is skipped or duplicated.
- Flush asserted at edge E: `to_compute.valid = 0` after E, and accepting resumes the cycle after flush deasserts.

## Structure
- Shared package `fir_pkg`:
  - `FIR_DATA_BUS` (packed `valid`, `data`).
  - `FIR_RATE`.
  - `FIR_CONT_TO_IN_RATE`.
  - FSM enum `IN_RATE_STATE` {SAMPLE, ZERO}.
- Sub-module: the existing zero-latency FIFO `d0fifo_wrap`, with `SIZE = DEPTH`, `WIDTH = $bits(FIR_DATA_BUS)` and flush tied to `from_cont.flush`.
- Remaining logic is one `always_ff` for state, `zcnt`, `rate_q` and output, plus one `always_comb` next-state block.

## Test plan
- Pass-through: `rate = 0`, DMA sends 0x11, 0x22, 0x33 back-to-back with `compute_ready = 1` → `to_compute` carries 0x11, 0x22, 0x33 valid on consecutive cycles, starting one cycle after the first push.
- Upsample: `rate = 2`, inputs 0x5, 0x7 → outputs 0x5, 0, 0, 0x7, 0, 0 with all six valid and contiguous.
- Backpressure and FIFO full:
  - Setup: `rate = 3`, `compute_ready = 0`, DMA streams 0xA0..0xA5.
  - Expected: `in_rate_ready` drops after 4 pushes plus the 1 held in the output register.
  - After releasing `compute_ready`, every sample is followed by exactly 3 zeros, with none lost.
- Mid-burst rate change: `rate` changes from 1 to 0 while emitting a zero after 0x9 → that zero completes, and the next sample 0xB passes with no zeros.
- Flush: assert flush for one cycle mid-ZERO with 2 entries in the FIFO → next cycle `to_compute.valid = 0`, FIFO empty. A new sample 0xC then emerges normally.
- Reset mid-operation: drop `rst_n` while in ZERO with `rate = 255` → outputs zero immediately, and the state is clean after release. `rate = 255` then yields 255 zeros per sample.
